// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes and state encoding shared by the seq_alu slice
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_ROL    = 4'd4;
  localparam logic [3:0] OP_ROR    = 4'd5;
  localparam logic [3:0] OP_PENC   = 4'd6;
  localparam logic [3:0] OP_GRAY   = 4'd7;
  localparam logic [3:0] OP_POPCNT = 4'd8;
  localparam logic [3:0] OP_PARITY = 4'd9;
  localparam logic [3:0] OP_AND    = 4'd10;
  localparam logic [3:0] OP_OR     = 4'd11;
  localparam logic [3:0] OP_NOT    = 4'd12;
  localparam logic [3:0] OP_XOR    = 4'd13;
  localparam logic [3:0] OP_GT     = 4'd14;
  localparam logic [3:0] OP_EQ     = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - iterative shift-add multiplier / restoring divider
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  // acc_q is the product high half / partial remainder, q_q the multiplier / quotient
  logic [WIDTH-1:0] acc_q, q_q, m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q, div_q;

  logic [WIDTH-1:0] acc_n, q_n;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;

  // One iteration of the engine; lo/hi expose the post-iteration value so the
  // final step can be captured by the top on the same edge it completes.
  always_comb begin
    add_sum  = {1'b0, acc_q} + {1'b0, m_q & {WIDTH{q_q[0]}}};
    rem_sh   = {acc_q, q_q[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - m_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, m_q}) begin
        acc_n = rem_diff;
        q_n   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = rem_sh[WIDTH-1:0];
        q_n   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = add_sum[WIDTH:1];
      q_n   = {add_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Load on start, then iterate WIDTH times counting down to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      q_q      <= a;
      m_q      <= b;
      cnt_q    <= CNT_W'(WIDTH - 1);
      active_q <= 1'b1;
      div_q    <= is_div;
    end else if (active_q) begin
      acc_q <= acc_n;
      q_q   <= q_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

  assign done = active_q && (cnt_q == '0);
  assign lo   = q_n;
  assign hi   = acc_n;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked multi-cycle ALU with registered result and flags
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_sign,
  output logic             flag_error,
  output logic             busy
);

  localparam int ENC_W = $clog2(WIDTH);

  state_t state_q, state_d;

  logic             start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] pop, penc;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_carry, sc_sign, sc_err;

  // MUL always iterates; DIV iterates unless the divisor is zero
  assign start = (state_q == ST_IDLE) && in_valid &&
                 ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Single-cycle datapath, evaluated on the live inputs at accept time
  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_sign  = 1'b0;
    sc_err   = 1'b0;
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    pop      = '0;
    penc     = '1;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + WIDTH'(a[i]);
      if (a[i]) penc = {{(WIDTH-ENC_W){1'b0}}, ENC_W'(i)};
    end
    case (op)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_sign  = sum[WIDTH-1];
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_sign  = diff[WIDTH-1];
      end
      OP_DIV:    sc_err = 1'b1;
      OP_ROL:    sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:    sc_res = {a[0], a[WIDTH-1:1]};
      OP_PENC:   sc_res = penc;
      OP_GRAY:   sc_res = a ^ (a >> 1);
      OP_POPCNT: sc_res = pop;
      OP_PARITY: sc_res = {{(WIDTH-1){1'b0}}, ~^a};
      OP_AND:    sc_res = a & b;
      OP_OR:     sc_res = a | b;
      OP_NOT:    sc_res = ~a;
      OP_XOR:    sc_res = a ^ b;
      OP_GT:     sc_res = {{(WIDTH-1){1'b0}}, a > b};
      OP_EQ:     sc_res = {{(WIDTH-1){1'b0}}, a == b};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = start ? ST_EXEC : ST_DONE;
      ST_EXEC: if (md_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers change only on the transition into DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result     <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_sign  <= 1'b0;
      flag_error <= 1'b0;
    end else if ((state_q == ST_IDLE) && in_valid && !start) begin
      result     <= sc_res;
      result_hi  <= sc_hi;
      flag_zero  <= (sc_res == '0);
      flag_carry <= sc_carry;
      flag_sign  <= sc_sign;
      flag_error <= sc_err;
    end else if ((state_q == ST_EXEC) && md_done) begin
      result     <= md_lo;
      result_hi  <= md_hi;
      flag_zero  <= (md_lo == '0);
      flag_carry <= 1'b0;
      flag_sign  <= md_lo[WIDTH-1];
      flag_error <= 1'b0;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule
